// File: rtl/ldl_round_mux.sv
// Output stage of the round-priority arbiter: steers the granted channel into a
// 2-entry buffer and holds the grant until the last beat of a multi-beat packet.
module ldl_round_mux #(
  parameter  int BIN_WIDTH  = 3,
  parameter  int DATA_WIDTH = 8,
  localparam int REQ_WIDTH  = 1 << BIN_WIDTH
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 arb_valid,
  input  logic [BIN_WIDTH-1:0]                 arb_bin,
  input  logic [REQ_WIDTH-1:0]                 arb_hot,
  output logic                                 arb_ready,
  input  logic [REQ_WIDTH-1:0]                 in_valid,
  input  logic [REQ_WIDTH-1:0][DATA_WIDTH-1:0] in_data,
  input  logic [REQ_WIDTH-1:0]                 in_last,
  output logic [REQ_WIDTH-1:0]                 in_ack,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [DATA_WIDTH-1:0]                out_data,
  output logic [BIN_WIDTH-1:0]                 out_bin,
  output logic                                 out_last
);

  typedef enum logic {IDLE, LOCK} state_e;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [BIN_WIDTH-1:0]  bin;
    logic                  last;
  } beat_t;

  state_e               state_q, state_d;
  logic [BIN_WIDTH-1:0] lock_bin_q, lock_bin_d;
  logic [1:0]           count_q, count_d;
  logic                 wr_ptr_q, rd_ptr_q;
  beat_t                mem_q [2];

  logic                 space;
  logic                 grant_push;
  logic                 lock_push;
  logic                 push;
  logic                 pop;
  logic [BIN_WIDTH-1:0] push_bin;
  beat_t                push_beat;

  always_comb begin
    space      = (count_q < 2'd2);
    // rst_n gates the handshakes so nothing is offered while reset is held
    arb_ready  = rst_n && (state_q == IDLE) && space;
    grant_push = arb_ready && arb_valid;
    lock_push  = rst_n && (state_q == LOCK) && in_valid[lock_bin_q] && space;
    push       = grant_push || lock_push;
    pop        = out_valid && out_ready;

    push_bin       = (state_q == IDLE) ? arb_bin : lock_bin_q;
    push_beat.data = in_data[push_bin];
    push_beat.bin  = push_bin;
    push_beat.last = in_last[push_bin];

    in_ack = '0;
    if (grant_push) begin
      in_ack = arb_hot;
    end else if (lock_push) begin
      in_ack[lock_bin_q] = 1'b1;
    end

    state_d    = state_q;
    lock_bin_d = lock_bin_q;
    if (grant_push) begin
      lock_bin_d = arb_bin;
      state_d    = in_last[arb_bin] ? IDLE : LOCK;
    end else if (lock_push && in_last[lock_bin_q]) begin
      state_d = IDLE;
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_bin_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      lock_bin_q <= lock_bin_d;
      count_q    <= count_d;
      if (push) begin
        mem_q[wr_ptr_q] <= push_beat;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

  assign out_valid = (count_q != 2'd0);
  assign out_data  = mem_q[rd_ptr_q].data;
  assign out_bin   = mem_q[rd_ptr_q].bin;
  assign out_last  = mem_q[rd_ptr_q].last;

endmodule

// File: tb/tb_ldl_round_mux.sv
// Directed and model-checked random bench for ldl_round_mux (BIN_WIDTH=3, DATA_WIDTH=8).
module tb_ldl_round_mux;
  localparam int BW = 3;
  localparam int DW = 8;
  localparam int RW = 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [BW-1:0] bin;
    logic          last;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  arb_valid;
  logic [BW-1:0]         arb_bin;
  logic [RW-1:0]         arb_hot;
  logic                  arb_ready;
  logic [RW-1:0]         in_valid;
  logic [RW-1:0][DW-1:0] in_data;
  logic [RW-1:0]         in_last;
  logic [RW-1:0]         in_ack;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW-1:0]         out_data;
  logic [BW-1:0]         out_bin;
  logic                  out_last;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ldl_round_mux #(.BIN_WIDTH(BW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .arb_valid(arb_valid), .arb_bin(arb_bin), .arb_hot(arb_hot), .arb_ready(arb_ready),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ack(in_ack),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_bin(out_bin), .out_last(out_last)
  );

  task automatic clear_inputs();
    arb_valid = 1'b0;
    arb_bin   = '0;
    arb_hot   = '0;
    in_valid  = '0;
    in_data   = '0;
    in_last   = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; out_ready = 1'b1;
    clear_inputs();
    arb_valid = 1'b1; arb_bin = 3'd2; arb_hot = 8'h04; in_valid = 8'h04; in_last = 8'h04;
    #12;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (arb_ready !== 1'b0) begin errors++; $display("FAIL reset_arb_ready: got %b expected 0", arb_ready); end
    checks++;
    if (in_ack !== 8'h00) begin errors++; $display("FAIL reset_in_ack: got %h expected 00", in_ack); end
    checks++;
    if ({out_data, out_bin, out_last} !== 12'h000)
      begin errors++; $display("FAIL reset_out_fields: got %h/%h/%b expected 0", out_data, out_bin, out_last); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if (arb_ready !== 1'b1) begin errors++; $display("FAIL post_reset_arb_ready: got %b expected 1", arb_ready); end
  endtask

  task automatic test_single_beat();
    @(negedge clk);
    out_ready = 1'b1;
    arb_valid = 1'b1; arb_bin = 3'd2; arb_hot = 8'h04;
    in_valid = 8'h04; in_data[2] = 8'h5A; in_last = 8'h04;
    #1;
    checks++;
    if (in_ack !== 8'h04) begin errors++; $display("FAIL single_ack: got %h expected 04", in_ack); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data, out_bin, out_last} !== {1'b1, 8'h5A, 3'd2, 1'b1})
      begin errors++; $display("FAIL single_out: got v%b %h/%h/%b expected v1 5a/2/1", out_valid, out_data, out_bin, out_last); end
    checks++;
    if (arb_ready !== 1'b1) begin errors++; $display("FAIL single_stays_idle: got %b expected 1", arb_ready); end
    @(negedge clk);
    clear_inputs();
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_packet_lock();
    logic          av [5] = '{1, 1, 1, 1, 0};
    logic [BW-1:0] ab [5] = '{5, 1, 1, 1, 0};
    logic [RW-1:0] iv [5] = '{8'h22, 8'h22, 8'h22, 8'h02, 8'h00};
    logic [DW-1:0] d5 [5] = '{8'h10, 8'h11, 8'h12, 8'h12, 8'h00};
    logic [RW-1:0] il [5] = '{8'h02, 8'h02, 8'h22, 8'h02, 8'h00};
    logic          er [5] = '{1, 0, 0, 1, 1};
    logic [RW-1:0] ea [5] = '{8'h20, 8'h20, 8'h20, 8'h02, 8'h00};
    logic          ov [5] = '{1, 1, 1, 1, 0};
    logic [DW-1:0] od [5] = '{8'h10, 8'h11, 8'h12, 8'h77, 8'h00};
    logic [BW-1:0] ob [5] = '{5, 5, 5, 1, 0};
    logic          ol [5] = '{0, 0, 1, 1, 0};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready  = 1'b1;
      arb_valid  = av[c]; arb_bin = ab[c]; arb_hot = 8'h01 << ab[c];
      in_valid   = iv[c]; in_last = il[c];
      in_data[5] = d5[c]; in_data[1] = 8'h77;
      #1;
      checks++;
      if (arb_ready !== er[c]) begin errors++; $display("FAIL lock_arb_ready[%0d]: got %b expected %b", c, arb_ready, er[c]); end
      checks++;
      if (in_ack !== ea[c]) begin errors++; $display("FAIL lock_ack[%0d]: got %h expected %h", c, in_ack, ea[c]); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== ov[c]) begin errors++; $display("FAIL lock_out_valid[%0d]: got %b expected %b", c, out_valid, ov[c]); end
      else if (ov[c] && {out_data, out_bin, out_last} !== {od[c], ob[c], ol[c]})
        begin errors++; $display("FAIL lock_out[%0d]: got %h/%h/%b expected %h/%h/%b", c, out_data, out_bin, out_last, od[c], ob[c], ol[c]); end
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_backpressure();
    logic          orr [8] = '{0, 0, 0, 0, 1, 1, 1, 1};
    logic          iv3 [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [DW-1:0] d3  [8] = '{8'hA0, 8'hA1, 8'hA2, 8'hA2, 8'hA2, 8'hA2, 8'hA3, 8'h00};
    logic          l3  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    logic [RW-1:0] ea  [8] = '{8'h08, 8'h08, 8'h00, 8'h00, 8'h00, 8'h08, 8'h08, 8'h00};
    logic          ov  [8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    logic [DW-1:0] od  [8] = '{8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'h00};
    logic          ol  [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      out_ready  = orr[c];
      arb_valid  = (c == 0); arb_bin = 3'd3; arb_hot = 8'h08;
      in_valid   = {4'b0, iv3[c], 3'b0};
      in_last    = {4'b0, l3[c], 3'b0};
      in_data[3] = d3[c];
      #1;
      checks++;
      if (in_ack !== ea[c]) begin errors++; $display("FAIL bp_ack[%0d]: got %h expected %h", c, in_ack, ea[c]); end
      if (c == 3) begin
        checks++;
        if (arb_ready !== 1'b0) begin errors++; $display("FAIL bp_arb_ready: got %b expected 0", arb_ready); end
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== ov[c]) begin errors++; $display("FAIL bp_out_valid[%0d]: got %b expected %b", c, out_valid, ov[c]); end
      else if (ov[c] && {out_data, out_bin, out_last} !== {od[c], 3'd3, ol[c]})
        begin errors++; $display("FAIL bp_out[%0d]: got %h/%h/%b expected %h/3/%b", c, out_data, out_bin, out_last, od[c], ol[c]); end
    end
    @(negedge clk); clear_inputs();
  endtask

  task automatic test_stall();
    logic [RW-1:0] iv [7] = '{8'h41, 8'h01, 8'h01, 8'h01, 8'h41, 8'h41, 8'h01};
    logic [DW-1:0] d6 [7] = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'h00};
    logic [RW-1:0] il [7] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h41, 8'h01};
    logic [BW-1:0] ab [7] = '{6, 0, 0, 0, 0, 0, 0};
    logic          er [7] = '{1, 0, 0, 0, 0, 0, 1};
    logic [RW-1:0] ea [7] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h40, 8'h40, 8'h01};
    logic          ov [7] = '{1, 0, 0, 0, 1, 1, 1};
    logic [DW-1:0] od [7] = '{8'hB0, 8'h00, 8'h00, 8'h00, 8'hB1, 8'hB2, 8'hC0};
    logic [BW-1:0] ob [7] = '{6, 0, 0, 0, 6, 6, 0};
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      out_ready  = 1'b1;
      arb_valid  = 1'b1; arb_bin = ab[c]; arb_hot = 8'h01 << ab[c];
      in_valid   = iv[c]; in_last = il[c];
      in_data[6] = d6[c]; in_data[0] = 8'hC0;
      #1;
      checks++;
      if (arb_ready !== er[c]) begin errors++; $display("FAIL stall_arb_ready[%0d]: got %b expected %b", c, arb_ready, er[c]); end
      checks++;
      if (in_ack !== ea[c]) begin errors++; $display("FAIL stall_ack[%0d]: got %h expected %h", c, in_ack, ea[c]); end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== ov[c]) begin errors++; $display("FAIL stall_out_valid[%0d]: got %b expected %b", c, out_valid, ov[c]); end
      else if (ov[c] && {out_data, out_bin} !== {od[c], ob[c]})
        begin errors++; $display("FAIL stall_out[%0d]: got %h/%h expected %h/%h", c, out_data, out_bin, od[c], ob[c]); end
    end
    @(negedge clk); clear_inputs();
    @(posedge clk);
  endtask

  task automatic test_reset_mid_packet();
    @(negedge clk);
    out_ready = 1'b1;
    arb_valid = 1'b1; arb_bin = 3'd4; arb_hot = 8'h10;
    in_valid = 8'h10; in_last = 8'h00; in_data[4] = 8'hD0;
    #1;
    checks++;
    if (in_ack !== 8'h10) begin errors++; $display("FAIL rmid_ack0: got %h expected 10", in_ack); end
    @(negedge clk);
    arb_valid = 1'b0; in_data[4] = 8'hD1;
    #1;
    checks++;
    if (in_ack !== 8'h10) begin errors++; $display("FAIL rmid_ack1: got %h expected 10", in_ack); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data} !== {1'b1, 8'hD1}) begin errors++; $display("FAIL rmid_beat1: got v%b %h expected v1 d1", out_valid, out_data); end
    @(negedge clk);
    in_data[4] = 8'hD2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, arb_ready, in_ack} !== 10'b0)
      begin errors++; $display("FAIL rmid_async: got v%b r%b ack%h expected all 0", out_valid, arb_ready, in_ack); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({arb_ready, in_ack} !== {1'b1, 8'h00})
      begin errors++; $display("FAIL rmid_idle: got r%b ack%h expected r1 ack00", arb_ready, in_ack); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_push: got %b expected 0", out_valid); end
    @(negedge clk);
    arb_valid = 1'b1; in_last = 8'h10; in_data[4] = 8'hE0;
    #1;
    checks++;
    if (in_ack !== 8'h10) begin errors++; $display("FAIL rmid_regrant: got %h expected 10", in_ack); end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, out_data, out_bin, out_last} !== {1'b1, 8'hE0, 3'd4, 1'b1})
      begin errors++; $display("FAIL rmid_regrant_out: got v%b %h/%h/%b expected v1 e0/4/1", out_valid, out_data, out_bin, out_last); end
    @(negedge clk); clear_inputs();
    @(posedge clk);
  endtask

  task automatic test_random();
    beat_t         q[$];
    logic          m_lock = 1'b0;
    logic [BW-1:0] m_bin = '0;
    logic [BW-1:0] pb;
    logic [RW-1:0] exp_ack;
    logic          space, gpush, lpush, exp_ov;
    int unsigned   start;
    int            ack_cnt = 0;
    int            out_cnt = 0;
    for (int c = 0; c < 604; c++) begin
      @(negedge clk);
      if (c < 600) begin
        in_valid  = RW'($urandom);
        in_last   = RW'($urandom);
        for (int k = 0; k < RW; k++) in_data[k] = DW'($urandom);
        out_ready = ($urandom_range(0, 3) != 0);
        arb_valid = 1'b0;
        arb_bin   = BW'($urandom);
        if (!m_lock) begin
          start = $urandom_range(0, RW - 1);
          for (int unsigned k = 0; k < RW; k++) begin
            if (!arb_valid && in_valid[(start + k) % RW]) begin
              arb_valid = 1'b1;
              arb_bin   = BW'((start + k) % RW);
            end
          end
        end else begin
          arb_valid = $urandom_range(0, 1) != 0;
        end
        arb_hot = 8'h01 << arb_bin;
      end else begin
        clear_inputs();
        out_ready = 1'b1;
      end
      space   = q.size() < 2;
      gpush   = !m_lock && arb_valid && space;
      lpush   = m_lock && in_valid[m_bin] && space;
      pb      = m_lock ? m_bin : arb_bin;
      exp_ack = gpush ? arb_hot : (lpush ? (8'h01 << m_bin) : 8'h00);
      exp_ov  = q.size() != 0;
      #1;
      checks++;
      if (in_ack !== exp_ack) begin errors++; $display("FAIL rnd_ack[%0d]: got %h expected %h", c, in_ack, exp_ack); end
      checks++;
      if (arb_ready !== (!m_lock && space))
        begin errors++; $display("FAIL rnd_arb_ready[%0d]: got %b expected %b", c, arb_ready, !m_lock && space); end
      checks++;
      if (out_valid !== exp_ov) begin errors++; $display("FAIL rnd_out_valid[%0d]: got %b expected %b", c, out_valid, exp_ov); end
      else if (exp_ov && {out_data, out_bin, out_last} !== q[0])
        begin errors++; $display("FAIL rnd_out[%0d]: got %h/%h/%b expected %h/%h/%b", c, out_data, out_bin, out_last, q[0].data, q[0].bin, q[0].last); end
      ack_cnt += $countones(in_ack);
      if (out_valid && out_ready) out_cnt++;
      @(posedge clk);
      if (exp_ov && out_ready) void'(q.pop_front());
      if (gpush || lpush) begin
        q.push_back('{data: in_data[pb], bin: pb, last: in_last[pb]});
        if (gpush) begin
          m_bin  = arb_bin;
          m_lock = !in_last[arb_bin];
        end else if (in_last[m_bin]) begin
          m_lock = 1'b0;
        end
      end
    end
    checks++;
    if (ack_cnt !== out_cnt) begin errors++; $display("FAIL rnd_ack_vs_out: got %0d acks expected %0d beats out", ack_cnt, out_cnt); end
    @(negedge clk);
    clear_inputs();
    m_lock = 1'b0;
  endtask

  initial begin
    out_ready = 1'b1;
    test_reset();
    test_single_beat();
    test_packet_lock();
    test_backpressure();
    test_stall();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ldl_round_mux.md
LDL_ROUND_MUX -- requirements
Module: LDL_round_mux

Downstream stage of the round-priority arbiter: consumes its grant (bin/hot/valid), steers the granted channel's data into a 2-entry output buffer, and holds the grant for multi-beat packets.

Interface
REQ-001 SHALL have parameter BIN_WIDTH, default 3, meaning the channel index width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning the payload width per beat.
REQ-003 SHALL have derived parameter REQ_WIDTH, default 1 << BIN_WIDTH, meaning the channel count (not overridden).
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port arb_valid, input, 1, arbiter grant valid.
REQ-007 SHALL have port arb_bin, input, BIN_WIDTH, granted channel index.
REQ-008 SHALL have port arb_hot, input, REQ_WIDTH, granted channel one-hot (consistent with arb_bin).
REQ-009 SHALL have port arb_ready, output, 1, grant accepted; arbiter advances its pointer on arb_valid && arb_ready.
REQ-010 SHALL have port in_valid, input, REQ_WIDTH, per-channel beat valid (also the arbiter's req).
REQ-011 SHALL have port in_data, input, REQ_WIDTH x DATA_WIDTH (packed 2-D), per-channel payload.
REQ-012 SHALL have port in_last, input, REQ_WIDTH, per-channel last-beat-of-packet flag.
REQ-013 SHALL have port in_ack, output, REQ_WIDTH, one-hot beat-consumed strobe per channel.
REQ-014 SHALL have port out_valid, output, 1, output beat valid.
REQ-015 SHALL have port out_ready, input, 1, downstream accepts the beat.
REQ-016 SHALL have ports out_data (DATA_WIDTH), out_bin (BIN_WIDTH) and out_last (1), all outputs: beat payload, source channel and last flag.

Function
REQ-017 SHALL implement states IDLE and LOCK plus a lock_bin register and a 2-entry FIFO with count 0..2.
REQ-018 SHALL define space = (count < 2), from registered state only, with no combinational path from out_ready to arb_ready or in_ack.
REQ-019 SHALL drive arb_ready = (state == IDLE) && space.
REQ-020 SHALL treat the cycle with arb_valid && arb_ready in IDLE as a grant push: write {in_data[arb_bin], arb_bin, in_last[arb_bin]} into the FIFO, set in_ack = arb_hot, and load lock_bin = arb_bin.
REQ-021 SHALL, on a grant push with in_last[arb_bin] = 0, move to LOCK; with in_last = 1, stay in IDLE.
REQ-022 SHALL, in LOCK, push {in_data[lock_bin], lock_bin, in_last[lock_bin]} and pulse in_ack[lock_bin] when in_valid[lock_bin] && space; no other channel is acked.
REQ-023 SHALL, in LOCK, return to IDLE on the push carrying in_last = 1, and hold LOCK while in_valid[lock_bin] = 0.
REQ-024 SHALL keep arb_ready = 0 in LOCK, so the arbiter's grant is frozen for the whole packet.
REQ-025 SHALL keep in_ack all-zero in any cycle without a push; in_ack is combinational and at most one bit is set.
REQ-026 SHALL pop the FIFO head when out_valid && out_ready.
REQ-027 SHALL drive out_valid = (count != 0), with out_data, out_bin and out_last taken from the head and stable while out_valid && !out_ready.
REQ-028 SHALL update count as +1 on push only, -1 on pop only, unchanged on simultaneous push and pop (legal at count 1; at count 0 the pushed beat becomes the head next cycle).
REQ-029 SHALL deliver a beat with latency 1: pushed at edge N, visible on out_* after edge N.
REQ-030 SHALL never push at count 2, even if out_ready = 1 that cycle.
REQ-031 SHALL have a throughput of 1 beat/cycle while out_ready = 1.
REQ-032 SHALL wrap FIFO read and write pointers modulo 2.
REQ-033 SHALL ignore arb_bin, arb_hot, in_data and in_last whenever no push occurs.

Reset
REQ-034 SHALL, with rst_n low (asynchronous assert, synchronous-safe deassert on clk), force state = IDLE, lock_bin = 0, count = 0, pointers = 0, and FIFO contents/out_data/out_bin/out_last = 0.
REQ-035 SHALL drive out_valid = 0, arb_ready = 0, and in_ack = 0 during reset.
REQ-036 SHALL, on reset mid-packet, abandon the packet, discard FIFO contents, and return to IDLE; the first post-reset push requires a new grant.

Verification
REQ-037 Single beats: BIN_WIDTH=3, DATA_WIDTH=8, out_ready=1, arb_valid=1, arb_bin=2, arb_hot=8'b00000100, in_valid[2]=1, in_data[2]=8'h5A, in_last[2]=1 -> in_ack=8'b00000100 same cycle; next cycle out_valid=1, out_data=8'h5A, out_bin=2, out_last=1; state stays IDLE.
REQ-038 Packet lock: grant ch5, 3 beats 8'h10, 8'h11, 8'h12 with last on the 3rd; arb_valid stays 1 for ch1 -> arb_ready=0 for 2 cycles after the grant; out_bin=5 for 3 consecutive beats; ch1 is acked only after the ch5 last beat.
REQ-039 Backpressure: out_ready=0 for 4 cycles during a 4-beat packet -> exactly 2 acks then in_ack=0; count=2; no beat lost or duplicated once out_ready=1; order preserved.
REQ-040 Stall inside LOCK: in_valid[lock_bin] drops for 3 cycles -> no ack, state LOCK, arb_ready=0; the stream resumes on reassert.
REQ-041 Reset mid-packet: rst_n=0 after 2 of 4 beats -> out_valid=0, in_ack=0 immediately (asynchronous); after release, state IDLE and arb_ready=1.
REQ-042 Random mix of in_valid, in_last, out_ready against a reference model -> per-channel order preserved, packets never interleaved, in_ack count equals out beat count.
